// File: rtl/wb_commit.sv
// wb_commit: register-file write-back arbiter.
// Channel A (in-order pipeline) owns the single write port whenever it is valid.
// Channel B (late MDU/CP0 results) is buffered in a small FIFO and drained on
// idle A cycles. pend_rs/pend_rt flag decode sources that still wait on B.
// Optional macro WB_COMMIT_LOAD_EXT_EN enables byte/half load extension on A.
// Handshake: B transfers on b_valid && b_ready; b_ready depends only on
// registered state, and A is never stalled.
module wb_commit #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       a_valid,
    input  logic [AW-1:0]              a_rw,
    input  logic [DW-1:0]              a_data,
    input  logic [2:0]                 a_loadtype,
    input  logic [1:0]                 a_addr_lo,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [AW-1:0]              b_rw,
    input  logic [DW-1:0]              b_data,
    input  logic [AW-1:0]              d_rs,
    input  logic [AW-1:0]              d_rt,
    output logic                       pend_rs,
    output logic                       pend_rt,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_waddr,
    output logic [DW-1:0]              rf_wdata,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rdy_en_q, rdy_en_d;
    logic [AW-1:0] mem_rw_q   [DEPTH];
    logic [AW-1:0] mem_rw_d   [DEPTH];
    logic [DW-1:0] mem_data_q [DEPTH];
    logic [DW-1:0] mem_data_d [DEPTH];

    logic [DW-1:0] a_wdata;
    logic          push;
    logic          pop;
    logic          full;

`ifdef WB_COMMIT_LOAD_EXT_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Select the addressed byte/half of the load word and extend it.
    always_comb begin
        ld_byte = a_data[{a_addr_lo, 3'b000} +: 8];
        ld_half = a_data[{a_addr_lo[1], 4'b0000} +: 16];
        case (a_loadtype)
            3'd1:    a_wdata = {{(DW-8){1'b0}}, ld_byte};
            3'd2:    a_wdata = {{(DW-8){ld_byte[7]}}, ld_byte};
            3'd3:    a_wdata = {{(DW-16){1'b0}}, ld_half};
            3'd4:    a_wdata = {{(DW-16){ld_half[15]}}, ld_half};
            default: a_wdata = a_data;
        endcase
    end
`else
    logic unused_load_ports;
    assign a_wdata           = a_data;
    assign unused_load_ports = ^{a_loadtype, a_addr_lo};
`endif

    // rdy_en_q keeps b_ready low during reset and raises it one edge later.
    assign full    = (count_q == CW'(DEPTH));
    assign b_ready = rdy_en_q && !full;
    assign push    = b_valid && b_ready && (b_rw != '0);
    assign pop     = !a_valid && (count_q != '0);

    // Write-port arbitration, FIFO pointers and storage update.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        rdy_en_d   = 1'b1;
        mem_rw_d   = mem_rw_q;
        mem_data_d = mem_data_q;

        if (a_valid) begin
            if (a_rw != '0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = a_rw;
                rf_wdata_d = a_wdata;
            end
        end else if (pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = mem_rw_q[rd_ptr_q];
            rf_wdata_d = mem_data_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + 1'b1;
        end

        if (push) begin
            mem_rw_d[wr_ptr_q]   = b_rw;
            mem_data_d[wr_ptr_q] = b_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pending-source detection over the incoming push and all live entries.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        pend_rs = 1'b0;
        pend_rt = 1'b0;
        if (push && (b_rw == d_rs)) pend_rs = 1'b1;
        if (push && (b_rw == d_rt)) pend_rt = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (mem_rw_q[idx] == d_rs) pend_rs = 1'b1;
                if (mem_rw_q[idx] == d_rt) pend_rt = 1'b1;
            end
        end
        if (d_rs == '0) pend_rs = 1'b0;
        if (d_rt == '0) pend_rt = 1'b0;
    end

    // State registers; reset empties the queue and clears the write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rdy_en_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_rw_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rdy_en_q   <= rdy_en_d;
            mem_rw_q   <= mem_rw_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign q_count  = count_q;

endmodule

// File: tb/tb_wb_commit.sv
// Testbench for wb_commit (DW=32, AW=5, DEPTH=4).
module tb_wb_commit;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int W  = AW + DW;

  logic          clk;
  logic          reset_n;
  logic          a_valid;
  logic [AW-1:0] a_rw;
  logic [DW-1:0] a_data;
  logic [2:0]    a_loadtype;
  logic [1:0]    a_addr_lo;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_rw;
  logic [DW-1:0] b_data;
  logic [AW-1:0] d_rs;
  logic [AW-1:0] d_rt;
  logic          pend_rs;
  logic          pend_rt;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [2:0]    q_count;

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];

  wb_commit #(.DW(DW), .AW(AW), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_rw(a_rw), .a_data(a_data),
    .a_loadtype(a_loadtype), .a_addr_lo(a_addr_lo),
    .b_valid(b_valid), .b_ready(b_ready), .b_rw(b_rw), .b_data(b_data),
    .d_rs(d_rs), .d_rt(d_rt), .pend_rs(pend_rs), .pend_rt(pend_rt),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_count(q_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // driver: advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: every register-file write must match the queue head
  always @(negedge clk) begin
    if (reset_n && rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%h required no write", rf_waddr, rf_wdata);
      end else begin
        chk("wb_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  logic [2:0]    lt_tab [6];
  logic [1:0]    lo_tab [6];
  logic [DW-1:0] ext_tab[6];
  logic [DW-1:0] exp_d;

  initial begin
    checks = 0; failures = 0;
    lt_tab[0] = 3'd2; lo_tab[0] = 2'd3; ext_tab[0] = 32'hFFFFFF80;
    lt_tab[1] = 3'd1; lo_tab[1] = 2'd3; ext_tab[1] = 32'h00000080;
    lt_tab[2] = 3'd4; lo_tab[2] = 2'd2; ext_tab[2] = 32'hFFFF80FF;
    lt_tab[3] = 3'd3; lo_tab[3] = 2'd0; ext_tab[3] = 32'h00000011;
    lt_tab[4] = 3'd2; lo_tab[4] = 2'd2; ext_tab[4] = 32'hFFFFFFFF;
    lt_tab[5] = 3'd6; lo_tab[5] = 2'd1; ext_tab[5] = 32'h80FF0011;

    reset_n = 1'b0; a_valid = 1'b0; a_rw = '0; a_data = '0;
    a_loadtype = '0; a_addr_lo = '0; b_valid = 1'b1; b_rw = 5'd3;
    b_data = 32'h33; d_rs = 5'd3; d_rt = 5'd3;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_pend", {pend_rs, pend_rt}, 0);
    b_valid = 1'b0; d_rs = '0; d_rt = '0;
    #2 reset_n = 1'b1;
    #1 chk("b_ready_before_edge", b_ready, 0);
    cyc();
    @(negedge clk);
    chk("b_ready_after_edge", b_ready, 1);

    // channel A word write, one cycle latency, then hold
    cyc();
    a_valid = 1'b1; a_rw = 5'd8; a_data = 32'h12345678; a_loadtype = 3'd0;
    exp_q.push_back({5'd8, 32'h12345678});
    cyc();
    a_valid = 1'b0;
    @(negedge clk);
    chk("a_we", rf_we, 1);
    chk("a_waddr", rf_waddr, 8);
    chk("a_wdata", rf_wdata, 32'h12345678);
    cyc();
    @(negedge clk);
    chk("idle_we", rf_we, 0);
    chk("hold_waddr", rf_waddr, 8);
    chk("hold_wdata", rf_wdata, 32'h12345678);

    // A to register 0 is dropped
    cyc();
    a_valid = 1'b1; a_rw = 5'd0; a_data = 32'hDEADBEEF;
    cyc();
    a_valid = 1'b0;
    @(negedge clk);
    chk("a_rw0_we", rf_we, 0);
    chk("a_rw0_hold", rf_wdata, 32'h12345678);

    // load extension vectors (pass-through when the macro is off)
    for (int i = 0; i < 6; i++) begin
      cyc();
      a_valid = 1'b1; a_rw = 5'd7; a_data = 32'h80FF0011;
      a_loadtype = lt_tab[i]; a_addr_lo = lo_tab[i];
`ifdef WB_COMMIT_LOAD_EXT_EN
      exp_d = ext_tab[i];
`else
      exp_d = 32'h80FF0011;
`endif
      exp_q.push_back({5'd7, exp_d});
    end
    cyc();
    a_valid = 1'b0; a_loadtype = '0; a_addr_lo = '0;
    @(negedge clk);
    chk("ld_last_we", rf_we, 1);

    // fill the queue while A owns the port, then drain in order
    cyc();
    a_valid = 1'b1; a_rw = 5'd0; a_data = '0;
    for (int i = 1; i <= 5; i++) begin
      b_valid = 1'b1; b_rw = AW'(i); b_data = 32'h100 + DW'(i); d_rs = AW'(i);
      @(negedge clk);
      if (i <= 4) begin
        chk("fill_b_ready", b_ready, 1);
        chk("fill_pend_rs", pend_rs, 1);
        exp_q.push_back({AW'(i), 32'h100 + DW'(i)});
      end else begin
        chk("full_b_ready", b_ready, 0);
        chk("full_q_count", q_count, 4);
        chk("full_pend_rs", pend_rs, 0);
      end
      cyc();
    end
    a_valid = 1'b0;
    @(negedge clk);
    chk("drain0_b_ready", b_ready, 0);
    chk("drain0_q_count", q_count, 4);
    chk("drain0_we", rf_we, 0);
    cyc();
    @(negedge clk);
    chk("drain1_b_ready", b_ready, 1);
    chk("drain1_q_count", q_count, 3);
    chk("drain1_we", rf_we, 1);
    exp_q.push_back({5'd5, 32'h105});
    for (int k = 2; k <= 5; k++) begin
      cyc();
      b_valid = 1'b0; d_rs = '0;
      @(negedge clk);
      chk("drain_we", rf_we, 1);
      chk("drain_q_count", q_count, 64'(5 - k));
    end
    cyc();
    @(negedge clk);
    chk("drain_done_we", rf_we, 0);
    chk("drain_exp_empty", 64'(exp_q.size()), 0);

    // pending tracking for rw=9
    cyc();
    b_valid = 1'b1; b_rw = 5'd9; b_data = 32'h999; d_rs = 5'd9; d_rt = 5'd4;
    @(negedge clk);
    chk("pend_push_rs", pend_rs, 1);
    chk("pend_push_rt", pend_rt, 0);
    chk("pend_push_ready", b_ready, 1);
    exp_q.push_back({5'd9, 32'h999});
    cyc();
    b_valid = 1'b0; a_valid = 1'b1; a_rw = 5'd0;
    @(negedge clk);
    chk("pend_held_rs", pend_rs, 1);
    chk("pend_held_cnt", q_count, 1);
    cyc();
    a_valid = 1'b0; d_rt = 5'd9;
    @(negedge clk);
    chk("pend_pop_rs", pend_rs, 1);
    chk("pend_pop_rt", pend_rt, 1);
    cyc();
    @(negedge clk);
    chk("pend_wr_we", rf_we, 1);
    chk("pend_wr_addr", rf_waddr, 9);
    chk("pend_after_rs", pend_rs, 0);
    chk("pend_after_rt", pend_rt, 0);

    // B push to register 0: acknowledged, not queued
    cyc();
    b_valid = 1'b1; b_rw = 5'd0; b_data = 32'h5; d_rs = '0; d_rt = '0;
    @(negedge clk);
    chk("zero_b_ready", b_ready, 1);
    chk("zero_pend", {pend_rs, pend_rt}, 0);
    cyc();
    b_valid = 1'b0;
    @(negedge clk);
    chk("zero_q_count", q_count, 0);
    cyc();
    @(negedge clk);
    chk("zero_no_we", rf_we, 0);

    // asynchronous reset with three queued entries
    cyc();
    a_valid = 1'b1; a_rw = 5'd0; b_valid = 1'b1; b_rw = 5'd11; b_data = 32'hB1;
    cyc();
    b_rw = 5'd12;
    cyc();
    b_rw = 5'd13;
    cyc();
    b_valid = 1'b0; a_rw = 5'd14; a_data = 32'hAAAA;
    @(negedge clk);
    chk("pre_rst_q_count", q_count, 3);
    cyc();
    a_valid = 1'b0; a_rw = '0;
    #1 chk("pre_rst_we", rf_we, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_we", rf_we, 0);
    chk("async_rst_q_count", q_count, 0);
    chk("async_rst_b_ready", b_ready, 0);
    chk("async_rst_waddr", rf_waddr, 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    cyc();
    @(negedge clk);
    chk("post_rst_b_ready", b_ready, 1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge clk);
      chk("post_rst_no_we", rf_we, 0);
      chk("post_rst_q_count", q_count, 0);
    end
    chk("final_exp_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 Parameter DW, default 32, width of register-file write data.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter DEPTH, default 4, late-result queue entries; power of two, 2..16.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 a_valid  in  1  in-order pipeline result present this cycle; never back-pressured.
REQ-008 a_rw  in  AW  destination register of channel A.
REQ-009 a_data  in  DW  ALU/PC8/memory word for channel A.
REQ-010 a_loadtype  in  3  0 word, 1 lbu, 2 lb, 3 lhu, 4 lh; 5-7 treated as word.
REQ-011 a_addr_lo  in  2  low byte address of load.
REQ-012 b_valid  in  1  late result (MDU LO/HI, CP0) offered.
REQ-013 b_ready  out  1  queue can accept channel B this cycle.
REQ-014 b_rw  in  AW  destination register of channel B.
REQ-015 b_data  in  DW  channel B data.
REQ-016 d_rs, d_rt  in  AW each  decode-stage source registers.
REQ-017 pend_rs, pend_rt  out  1 each  source matches a queued or in-flight B destination.
REQ-018 rf_we  out  1  registered register-file write enable.
REQ-019 rf_waddr  out  AW  registered write address.
REQ-020 rf_wdata  out  DW  registered write data; also the W-stage forwarding source.
REQ-021 q_count  out  clog2(DEPTH+1)  current queue occupancy.

Function
REQ-022 Channel A SHALL be written on rf_* exactly one cycle after a_valid sampled high.
REQ-023 Channel B SHALL be pushed into a FIFO when b_valid && b_ready; b_ready = !full, computed from registered occupancy only (no push into a full queue even on a same-cycle pop).
REQ-024 Each cycle with a_valid low and queue non-empty, the head SHALL be popped and written on rf_* the next cycle; minimum B latency is therefore 2 cycles, in FIFO order.
REQ-025 a_valid high SHALL always win the write port; the queue head holds until a cycle with a_valid low.
REQ-026 Results with destination 0 SHALL be discarded: A gives rf_we=0; B is acknowledged (b_ready honoured) but not enqueued.
REQ-027 rf_waddr/rf_wdata SHALL hold their last value when rf_we is 0.
REQ-028 pend_rs SHALL be 1 when d_rs != 0 and equals b_rw of an accepted push this cycle, any valid queue entry, or the entry being popped this cycle; pend_rt likewise; combinational.
REQ-029 Simultaneous push and pop SHALL leave q_count unchanged; pointers wrap modulo DEPTH.
REQ-030 Upstream SHALL interlock on pend_*; block performs no ordering repair between A and B to the same register.

Reset
REQ-031 While reset_n is low: rf_we=0, rf_waddr=0, rf_wdata=0, queue empty, q_count=0, b_ready=0, pend_*=0.
REQ-032 Reset assertion mid-operation SHALL discard all queued entries; b_ready SHALL rise on the first clk edge after reset_n deasserts.

Configuration
REQ-033 Macro WB_COMMIT_LOAD_EXT_EN: when defined, channel A data SHALL be extended per a_loadtype: byte = a_data[8*a_addr_lo+:8], half = a_data[16*a_addr_lo[1]+:16], zero- or sign-extended to DW.
REQ-034 When undefined, a_data SHALL pass unchanged; a_loadtype and a_addr_lo remain as ports and are ignored.

Verification
REQ-035 a_valid=1, a_rw=8, a_data=0x12345678, word -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x12345678.
REQ-036 LOAD_EXT_EN, a_loadtype=2, a_addr_lo=3, a_data=0x80FF0011 -> rf_wdata=0xFFFFFF80; same without macro -> 0x80FF0011.
REQ-037 DEPTH=4, a_valid held high, five B pushes (rw 1..5) -> b_ready=0 after fourth, q_count=4; drop a_valid -> writes rw 1,2,3,4 on consecutive cycles, then 5 accepted.
REQ-038 B push rw=9 with d_rs=9 -> pend_rs=1 same cycle, stays 1 until the cycle after rw=9 is written; b_rw=0 push -> q_count unchanged, pend_*=0.
REQ-039 Queue holding 3 entries, reset_n pulsed low asynchronously between edges -> rf_we=0 and q_count=0 immediately; no queued write appears afterward.
